// File: rtl/smsdac8_pkg.sv
// Shared types and constants for the 8-bit segmented DAC decode monitor.
// Pairs are indexed 0..6 from the 64-weight pair down to the 1-weight pair.
package smsdac8_pkg;

    localparam int NPAIRS = 7;

    typedef logic [7:0] code_t;

    localparam code_t PAIR_WT [NPAIRS] = '{8'd64, 8'd32, 8'd16, 8'd8, 8'd4, 8'd2, 8'd1};

    // Returns {a, b} for pair idx; the upper bit of each pair is the a element.
    function automatic logic [1:0] pair_bits(input logic [7:0] seg_hi,
                                             input logic [5:0] seg_lo,
                                             input int unsigned idx);
        logic [13:0] all_bits;
        logic [13:0] shifted;
        all_bits = {seg_hi, seg_lo};
        shifted  = all_bits << (2 * idx);
        return shifted[13:12];
    endfunction

endpackage

// File: rtl/smsdac8_pair_acc.sv
// One saturating signed usage-imbalance accumulator for a unit-element pair,
// with a sticky flag once |acc| exceeds BOUND.
module smsdac8_pair_acc #(
    parameter int ACC_W = 6,
    parameter int BOUND = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    input  logic a,
    input  logic b,
    output logic over
);

    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic signed [ACC_W-1:0] ACC_ONE = {{(ACC_W-1){1'b0}}, 1'b1};

    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_nxt;
    int                      acc_int;
    logic                    over_nxt;

    always_comb begin
        acc_nxt = acc;
        if (a && !b && acc != ACC_MAX)
            acc_nxt = acc + ACC_ONE;
        else if (!a && b && acc != ACC_MIN)
            acc_nxt = acc - ACC_ONE;
        acc_int  = int'(acc_nxt);
        over_nxt = (acc_int > BOUND) || (acc_int < -BOUND);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc  <= '0;
            over <= 1'b0;
        end else if (clr) begin
            acc  <= '0;
            over <= 1'b0;
        end else if (en) begin
            acc <= acc_nxt;
            if (over_nxt)
                over <= 1'b1;
        end
    end

endmodule

// File: rtl/smsdac8_decode_monitor.sv
// Decodes the 14 DAC unit elements back to a level and checks it against the
// latency-aligned reference code. Per-pair imbalance tracking under SMSDAC_IMBAL_EN.
module smsdac8_decode_monitor
    import smsdac8_pkg::*;
#(
    parameter int DAC_LAT = 2,
    parameter int ERR_W   = 8,
    parameter int ACC_W   = 6,
    parameter int BOUND   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [7:0]       seg_hi,
    input  logic [5:0]       seg_lo,
    input  logic [7:0]       ref_code,
    input  logic             clr,
    output logic [7:0]       dec_code,
    output logic             dec_valid,
    output logic             mismatch,
    output logic [ERR_W-1:0] err_cnt,
    output logic             imbal_flag
);

    localparam int PRIME_MAX = DAC_LAT - 1;

    logic [8:0] dec_sum;
    logic [1:0] pb;
    code_t      ref_dly;
    logic [2:0] prime_cnt;
    logic       primed;
    logic       mismatch_d;

    always_comb begin
        dec_sum = '0;
        pb      = '0;
        for (int i = 0; i < NPAIRS; i++) begin
            pb      = pair_bits(seg_hi, seg_lo, i);
            dec_sum = dec_sum + 9'(PAIR_WT[i]) * (9'(pb[1]) + 9'(pb[0]));
        end
    end

    // Delay counted in valid samples: the tap holds the ref of DAC_LAT-1 samples ago.
    generate
        if (DAC_LAT == 1) begin : g_nodly
            assign ref_dly = ref_code;
        end else begin : g_dly
            code_t ref_sr [DAC_LAT-1];
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < DAC_LAT-1; i++)
                        ref_sr[i] <= '0;
                end else if (in_valid) begin
                    ref_sr[0] <= ref_code;
                    for (int i = 1; i < DAC_LAT-1; i++)
                        ref_sr[i] <= ref_sr[i-1];
                end
            end
            assign ref_dly = ref_sr[DAC_LAT-2];
        end
    endgenerate

    assign primed     = (prime_cnt == 3'(PRIME_MAX));
    assign mismatch_d = in_valid && !clr && primed && (dec_sum[7:0] != ref_dly);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prime_cnt <= '0;
            err_cnt   <= '0;
            mismatch  <= 1'b0;
            dec_valid <= 1'b0;
            dec_code  <= '0;
        end else begin
            dec_valid <= in_valid;
            mismatch  <= mismatch_d;
            if (in_valid)
                dec_code <= dec_sum[7:0];
            if (clr) begin
                prime_cnt <= '0;
                err_cnt   <= '0;
            end else begin
                if (in_valid && !primed)
                    prime_cnt <= prime_cnt + 3'd1;
                if (mismatch_d && err_cnt != '1)
                    err_cnt <= err_cnt + 1'b1;
            end
        end
    end

`ifdef SMSDAC_IMBAL_EN
    logic [NPAIRS-1:0] pair_over;

    for (genvar g = 0; g < NPAIRS; g++) begin : g_acc
        logic [1:0] ab;
        assign ab = pair_bits(seg_hi, seg_lo, g);
        smsdac8_pair_acc #(
            .ACC_W (ACC_W),
            .BOUND (BOUND)
        ) u_acc (
            .clk   (clk),
            .rst_n (rst_n),
            .clr   (clr),
            .en    (in_valid),
            .a     (ab[1]),
            .b     (ab[0]),
            .over  (pair_over[g])
        );
    end

    assign imbal_flag = |pair_over;
`else
    assign imbal_flag = 1'b0;
`endif

endmodule

// File: tb/tb_smsdac8_decode_monitor.sv
// Randomized self-checking bench for smsdac8_decode_monitor with a sample-level reference model.
module tb_smsdac8_decode_monitor;

    localparam int LAT     = 2;
    localparam int ERR_W   = 8;
    localparam int ACC_W   = 6;
    localparam int BOUND   = 8;
    localparam int ERR_MAX = (1 << ERR_W) - 1;
    localparam int ACC_HI  = (1 << (ACC_W - 1)) - 1;
    localparam int ACC_LO  = -(1 << (ACC_W - 1));
    localparam int WT [7]  = '{64, 32, 16, 8, 4, 2, 1};

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic [7:0]       seg_hi;
    logic [5:0]       seg_lo;
    logic [7:0]       ref_code;
    logic             clr;
    logic [7:0]       dec_code;
    logic             dec_valid;
    logic             mismatch;
    logic [ERR_W-1:0] err_cnt;
    logic             imbal_flag;

    int vectors     = 0;
    int miscompares = 0;

    // reference model state
    int hist [$];
    int prime, err, e_dec;
    int acc [7];
    bit flag, e_dv, e_mis;

    always #5 clk = ~clk;

    smsdac8_decode_monitor #(
        .DAC_LAT (LAT),
        .ERR_W   (ERR_W),
        .ACC_W   (ACC_W),
        .BOUND   (BOUND)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .seg_hi     (seg_hi),
        .seg_lo     (seg_lo),
        .ref_code   (ref_code),
        .clr        (clr),
        .dec_code   (dec_code),
        .dec_valid  (dec_valid),
        .mismatch   (mismatch),
        .err_cnt    (err_cnt),
        .imbal_flag (imbal_flag)
    );

    function automatic int pair_cnt(logic [7:0] hi, logic [5:0] lo, int i, output int d);
        logic [13:0] t;
        t = {hi, lo} >> (12 - 2 * i);
        d = int'(t[1]) - int'(t[0]);
        return int'(t[1]) + int'(t[0]);
    endfunction

    function automatic int decode_model(logic [7:0] hi, logic [5:0] lo);
        int s, d;
        s = 0;
        for (int i = 0; i < 7; i++)
            s += WT[i] * pair_cnt(hi, lo, i, d);
        return s;
    endfunction

    // Random valid element pattern whose weighted sum equals code.
    function automatic void shape(input int code, output logic [7:0] hi, output logic [5:0] lo);
        logic [13:0] b, pv;
        int r, lo_n, hi_n, n, maxrest;
        b = '0;
        r = code;
        for (int i = 0; i < 7; i++) begin
            maxrest = 2 * (WT[i] - 1);
            lo_n = (r > maxrest) ? (r - maxrest + WT[i] - 1) / WT[i] : 0;
            hi_n = (r / WT[i] > 2) ? 2 : r / WT[i];
            n    = int'($urandom_range(hi_n, lo_n));
            r   -= n * WT[i];
            pv   = (n == 2) ? 14'd3 : (n == 1) ? (($urandom_range(1) == 1) ? 14'd2 : 14'd1) : 14'd0;
            b    = b | (pv << (12 - 2 * i));
        end
        hi = b[13:6];
        lo = b[5:0];
    endfunction

    function automatic void model_reset();
        hist.delete();
        prime = 0;
        err   = 0;
        e_dec = 0;
        e_dv  = 0;
        e_mis = 0;
        flag  = 0;
        for (int i = 0; i < 7; i++) acc[i] = 0;
    endfunction

    function automatic void model_step(logic [7:0] hi, logic [5:0] lo, int rc, bit v, bit c);
        int rd, d;
        e_mis = 0;
        e_dv  = v;
        if (v) e_dec = decode_model(hi, lo);
        if (c) begin
            err = 0; prime = 0; flag = 0;
            for (int i = 0; i < 7; i++) acc[i] = 0;
        end else if (v) begin
            if (prime >= LAT - 1) begin
                rd = (LAT == 1) ? rc : hist[hist.size() - (LAT - 1)];
                if (rd != e_dec) begin
                    e_mis = 1;
                    if (err < ERR_MAX) err++;
                end
            end else begin
                prime++;
            end
            for (int i = 0; i < 7; i++) begin
                void'(pair_cnt(hi, lo, i, d));
                acc[i] += d;
                if (acc[i] > ACC_HI) acc[i] = ACC_HI;
                if (acc[i] < ACC_LO) acc[i] = ACC_LO;
                if (acc[i] > BOUND || acc[i] < -BOUND) flag = 1;
            end
        end
        if (v) begin
            hist.push_back(rc);
            if (hist.size() > 16) void'(hist.pop_front());
        end
    endfunction

    task automatic step(input logic [7:0] hi, input logic [5:0] lo, input logic [7:0] rc,
                        input logic v, input logic c);
        bit ef;
        seg_hi   = hi;
        seg_lo   = lo;
        ref_code = rc;
        in_valid = v;
        clr      = c;
        @(posedge clk);
        #1;
        model_step(hi, lo, int'(rc), v, c);
`ifdef SMSDAC_IMBAL_EN
        ef = flag;
`else
        ef = 1'b0;
`endif
        vectors++;
        if (dec_valid !== e_dv) begin
            miscompares++;
            $display("FAIL dec_valid: got %b want %b at %0t", dec_valid, e_dv, $time);
        end
        if (dec_code !== 8'(e_dec)) begin
            miscompares++;
            $display("FAIL dec_code: got %0d want %0d at %0t", dec_code, e_dec, $time);
        end
        if (mismatch !== e_mis) begin
            miscompares++;
            $display("FAIL mismatch: got %b want %b at %0t", mismatch, e_mis, $time);
        end
        if (err_cnt !== ERR_W'(err)) begin
            miscompares++;
            $display("FAIL err_cnt: got %0d want %0d at %0t", err_cnt, err, $time);
        end
        if (imbal_flag !== ef) begin
            miscompares++;
            $display("FAIL imbal_flag: got %b want %b at %0t", imbal_flag, ef, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        vectors++;
        if ({dec_code, dec_valid, mismatch, err_cnt, imbal_flag} !== '0) begin
            miscompares++;
            $display("FAIL %s: got dec=%0d dv=%b mis=%b err=%0d imb=%b want all 0",
                     tag, dec_code, dec_valid, mismatch, err_cnt, imbal_flag);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; clr = 1'b0;
        seg_hi = '0; seg_lo = '0; ref_code = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset_state");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_stream();
        logic [7:0] hi;
        logic [5:0] lo;
        int prev = 0;
        for (int c = 0; c <= 254; c++) begin
            if ($urandom_range(3) == 0)
                step(8'($urandom), 6'($urandom), 8'($urandom), 1'b0, 1'b0);
            shape(prev, hi, lo);
            step(hi, lo, 8'(c), 1'b1, 1'b0);
            prev = c;
        end
    endtask

    task automatic test_single_error();
        logic [7:0] hi;
        logic [5:0] lo;
        step('0, '0, 8'd0, 1'b0, 1'b1);
        shape(0, hi, lo);
        step(hi, lo, 8'd200, 1'b1, 1'b0);
        shape(200, hi, lo);
        hi[7] = 1'b0;
        step(hi, lo, 8'd10, 1'b1, 1'b0);
        vectors++;
        if (dec_code !== 8'd136 || mismatch !== 1'b1 || err_cnt !== ERR_W'(1)) begin
            miscompares++;
            $display("FAIL single_error: got dec=%0d mis=%b err=%0d want dec=136 mis=1 err=1",
                     dec_code, mismatch, err_cnt);
        end
        shape(10, hi, lo);
        step(hi, lo, 8'd20, 1'b1, 1'b0);
    endtask

    task automatic test_saturate();
        logic [7:0] hi;
        logic [5:0] lo;
        step('0, '0, 8'd0, 1'b0, 1'b1);
        for (int i = 0; i < 300; i++) begin
            shape(int'($urandom_range(254)), hi, lo);
            step(hi, lo, 8'd255, 1'b1, 1'b0);
        end
        vectors++;
        if (err_cnt !== ERR_W'(ERR_MAX)) begin
            miscompares++;
            $display("FAIL err_saturate: got %0d want %0d", err_cnt, ERR_MAX);
        end
    endtask

    task automatic test_clr_collision();
        logic [7:0] hi;
        logic [5:0] lo;
        shape(int'($urandom_range(254)), hi, lo);
        step(hi, lo, 8'd255, 1'b1, 1'b1);
        vectors++;
        if (err_cnt !== '0 || mismatch !== 1'b0) begin
            miscompares++;
            $display("FAIL clr_collision: got err=%0d mis=%b want err=0 mis=0", err_cnt, mismatch);
        end
        shape(int'($urandom_range(254)), hi, lo);
        step(hi, lo, 8'd255, 1'b1, 1'b0);
        vectors++;
        if (mismatch !== 1'b0) begin
            miscompares++;
            $display("FAIL clr_reprime: got mis=%b want 0", mismatch);
        end
        shape(int'($urandom_range(254)), hi, lo);
        step(hi, lo, 8'd255, 1'b1, 1'b0);
    endtask

    task automatic test_imbal();
        bit want;
        step('0, '0, 8'd0, 1'b0, 1'b1);
        for (int i = 1; i <= 9; i++) begin
            step(8'h80, 6'h00, 8'($urandom_range(254)), 1'b1, 1'b0);
`ifdef SMSDAC_IMBAL_EN
            want = (i == 9);
`else
            want = 1'b0;
`endif
            if (i >= 8) begin
                vectors++;
                if (imbal_flag !== want) begin
                    miscompares++;
                    $display("FAIL imbal_sample%0d: got %b want %b", i, imbal_flag, want);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] hi;
        logic [5:0] lo;
        step('0, '0, 8'd0, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            shape(int'($urandom_range(254)), hi, lo);
            step(hi, lo, 8'd255, 1'b1, 1'b0);
        end
        vectors++;
        if (err_cnt !== ERR_W'(5)) begin
            miscompares++;
            $display("FAIL pre_reset_err: got %0d want 5", err_cnt);
        end
        #2 rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            shape(int'($urandom_range(254)), hi, lo);
            step(hi, lo, 8'd255, 1'b1, 1'b0);
        end
    endtask

    task automatic test_random();
        logic [7:0] hi;
        logic [5:0] lo;
        int last_ref = 0;
        int rc;
        for (int i = 0; i < 400; i++) begin
            rc = int'($urandom_range(254));
            if ($urandom_range(1) == 0) begin
                shape(last_ref, hi, lo);
            end else begin
                hi = 8'($urandom);
                lo = 6'($urandom);
            end
            if ($urandom_range(3) != 0) begin
                step(hi, lo, 8'(rc), 1'b1, 1'($urandom_range(19) == 0));
                last_ref = rc;
            end else begin
                step(hi, lo, 8'(rc), 1'b0, 1'($urandom_range(19) == 0));
            end
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_single_error();
        test_saturate();
        test_clr_collision();
        test_imbal();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
